// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift-and-correct step per clock.
// Optional macro BCD_BLANK_EN adds a registered leading-zero blanking mask.
module bin2bcd_seq #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGITS = 3
) (
   input  logic                  CLK100MHZ,
   input  logic                  CPU_RESETN,
   input  logic [WIDTH-1:0]      bin_in,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  overflow
`ifdef BCD_BLANK_EN
   ,
   output logic [DIGITS-1:0]     blank
`endif
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam int unsigned BcdW = 4 * DIGITS;
   localparam int unsigned CatW = BcdW + WIDTH + 1;

   typedef enum logic {StIdle, StShift} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  sr_q, sr_d;
   logic [BcdW-1:0]   acc_q, acc_d;
   logic              sticky_q, sticky_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              done_q, done_d;
   logic [BcdW-1:0]   bcd_q, bcd_d;
   logic              ovf_q, ovf_d;

   logic [BcdW-1:0]   acc_corr;
   logic [CatW-1:0]   cat;
   logic [BcdW-1:0]   acc_next;
   logic              carry_out;
   logic              last_iter;

   // Add-3 correction on every digit, then one left shift of {carry, acc, sr}.
   always_comb begin
      acc_corr = acc_q;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) begin
            acc_corr[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
         end
      end
      cat       = {1'b0, acc_corr, sr_q} << 1;
      acc_next  = cat[CatW-2:WIDTH];
      carry_out = cat[CatW-1];
   end

   assign last_iter = (state_q == StShift) && (cnt_q == CntW'(1));

   always_comb begin
      state_d  = state_q;
      sr_d     = sr_q;
      acc_d    = acc_q;
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      bcd_d    = bcd_q;
      ovf_d    = ovf_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               sr_d     = bin_in;
               acc_d    = '0;
               sticky_d = 1'b0;
               cnt_d    = CntW'(WIDTH);
               state_d  = StShift;
            end
         end
         StShift: begin
            sr_d     = cat[WIDTH-1:0];
            acc_d    = acc_next;
            sticky_d = sticky_q | carry_out;
            cnt_d    = cnt_q - CntW'(1);
            if (last_iter) begin
               bcd_d   = acc_next;
               ovf_d   = sticky_q | carry_out;
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state_q  <= StIdle;
         sr_q     <= '0;
         acc_q    <= '0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         bcd_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sr_q     <= sr_d;
         acc_q    <= acc_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         bcd_q    <= bcd_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy     = (state_q == StShift);
   assign done     = done_q;
   assign bcd_out  = bcd_q;
   assign overflow = ovf_q;

`ifdef BCD_BLANK_EN
   logic [DIGITS-1:0] blank_q, blank_d;
   logic              nonzero_above;

   // Scan from the top digit down; the ones digit is never blanked.
   always_comb begin
      blank_d       = blank_q;
      nonzero_above = 1'b0;
      if (last_iter) begin
         blank_d = '0;
         for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            nonzero_above = nonzero_above | (acc_next[4*i +: 4] != 4'd0);
            blank_d[i]    = ~nonzero_above;
         end
      end
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         blank_q <= '0;
      end else begin
         blank_q <= blank_d;
      end
   end

   assign blank = blank_q;
`endif

endmodule
